// File: rtl/alu_multicycle.sv
// ----------------------------------------------------------------------------
// alu_multicycle
//   Sequential execute-stage ALU. Logic, add/sub and signed compare finish in
//   one cycle; unsigned multiply (shift-add) and unsigned divide (restoring)
//   iterate one bit per cycle for WIDTH cycles.
//
//   Ports
//     clk        rising-edge clock
//     reset      asynchronous active-low reset
//     start      request, sampled only while idle
//     sel        opcode (captured with start)
//     src_a      operand A / multiplicand / dividend (captured with start)
//     src_b      operand B / multiplier / divisor    (captured with start)
//     busy       high in every state except IDLE
//     done       one-cycle pulse, results valid from this cycle
//     result_lo  primary result (low product / quotient)
//     result_hi  high product / remainder, 0 for single-cycle ops
//     zero       result_lo == 0, updated with done
//     div_zero   DIVU with src_b == 0, set with done, cleared on next start
// ----------------------------------------------------------------------------
module alu_multicycle #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       sel,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi,
   output logic             zero,
   output logic             div_zero
);

   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_XOR  = 3'b011;
   localparam logic [2:0] OP_SUB  = 3'b100;
   localparam logic [2:0] OP_MULU = 3'b101;
   localparam logic [2:0] OP_SLT  = 3'b110;
   localparam logic [2:0] OP_DIVU = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_FIN  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   // acc: running high product / partial remainder
   // lo : multiplier shifting out, low product shifting in
   //      or dividend shifting out, quotient shifting in
   // opb: multiplicand / divisor
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] res_lo_q, res_lo_d;
   logic [WIDTH-1:0] res_hi_q, res_hi_d;
   logic             zero_q, zero_d;
   logic             dz_q, dz_d;

   // ------------------------------------------------------------------
   // Single-cycle result, straight from the live operands (only used in
   // the accepting cycle, so no latched copy is needed).
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] alu_res;
   logic             slt_bit;

   assign slt_bit = $signed(src_a) < $signed(src_b);

   always_comb begin
      alu_res = '0;
      unique case (sel)
         OP_AND:  alu_res = src_a & src_b;
         OP_OR:   alu_res = src_a | src_b;
         OP_ADD:  alu_res = src_a + src_b;
         OP_XOR:  alu_res = src_a ^ src_b;
         OP_SUB:  alu_res = src_a - src_b;
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
         default: alu_res = '0;
      endcase
   end

   // ------------------------------------------------------------------
   // Shift-add multiply step: add multiplicand when the current multiplier
   // LSB is set, then shift the {acc, lo} pair right by one. The carry out
   // of the add lands in the top bit of acc.
   // ------------------------------------------------------------------
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH-1:0] mul_hi, mul_lo;

   assign mul_sum = {1'b0, acc_q} + {1'b0, opb_q & {WIDTH{lo_q[0]}}};
   assign mul_hi  = mul_sum[WIDTH:1];
   assign mul_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};

   // ------------------------------------------------------------------
   // Restoring divide step: shift the next dividend bit into the partial
   // remainder, trial-subtract the divisor and keep the difference only if
   // it did not go negative. Since rem < divisor, the shifted value is below
   // 2*divisor, so bit WIDTH of the difference is a reliable sign.
   // ------------------------------------------------------------------
   logic [WIDTH:0]   div_sh, div_diff;
   logic             div_ok;
   logic [WIDTH-1:0] div_rem, div_quo;

   assign div_sh   = {acc_q, lo_q[WIDTH-1]};
   assign div_diff = div_sh - {1'b0, opb_q};
   assign div_ok   = ~div_diff[WIDTH];
   assign div_rem  = div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
   assign div_quo  = {lo_q[WIDTH-2:0], div_ok};

   // ------------------------------------------------------------------
   // Next-state / datapath control
   // ------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      lo_d     = lo_q;
      opb_d    = opb_q;
      cnt_d    = cnt_q;
      res_lo_d = res_lo_q;
      res_hi_d = res_hi_q;
      zero_d   = zero_q;
      dz_d     = dz_q;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               dz_d = 1'b0;
               if (sel == OP_MULU) begin
                  acc_d   = '0;
                  lo_d    = src_b;
                  opb_d   = src_a;
                  cnt_d   = CNT_W'(WIDTH);
                  state_d = S_MUL;
               end else if (sel == OP_DIVU) begin
                  if (src_b == '0) begin
                     // Divide by zero short-circuits straight to FIN.
                     res_lo_d = '1;
                     res_hi_d = src_a;
                     zero_d   = 1'b0;
                     dz_d     = 1'b1;
                     state_d  = S_FIN;
                  end else begin
                     acc_d   = '0;
                     lo_d    = src_a;
                     opb_d   = src_b;
                     cnt_d   = CNT_W'(WIDTH);
                     state_d = S_DIV;
                  end
               end else begin
                  res_lo_d = alu_res;
                  res_hi_d = '0;
                  zero_d   = (alu_res == '0);
                  state_d  = S_FIN;
               end
            end
         end

         S_MUL: begin
            acc_d = mul_hi;
            lo_d  = mul_lo;
            cnt_d = cnt_q - CNT_W'(1);
            // Results are written on the last iteration so they are
            // already visible during the FIN (done) cycle.
            if (cnt_q == CNT_W'(1)) begin
               res_lo_d = mul_lo;
               res_hi_d = mul_hi;
               zero_d   = (mul_lo == '0);
               state_d  = S_FIN;
            end
         end

         S_DIV: begin
            acc_d = div_rem;
            lo_d  = div_quo;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               res_lo_d = div_quo;
               res_hi_d = div_rem;
               zero_d   = (div_quo == '0);
               state_d  = S_FIN;
            end
         end

         S_FIN: begin
            // start is deliberately ignored here.
            state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         acc_q    <= '0;
         lo_q     <= '0;
         opb_q    <= '0;
         cnt_q    <= '0;
         res_lo_q <= '0;
         res_hi_q <= '0;
         zero_q   <= 1'b0;
         dz_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         lo_q     <= lo_d;
         opb_q    <= opb_d;
         cnt_q    <= cnt_d;
         res_lo_q <= res_lo_d;
         res_hi_q <= res_hi_d;
         zero_q   <= zero_d;
         dz_q     <= dz_d;
      end
   end

   // done and busy decode directly from the state register, so both are
   // glitch-free and drop with the async reset.
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_FIN);
   assign result_lo = res_lo_q;
   assign result_hi = res_hi_q;
   assign zero      = zero_q;
   assign div_zero  = dz_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// ----------------------------------------------------------------------------
// tb_alu_multicycle
//   Self-checking bench for alu_multicycle (WIDTH = 32): reset/idle checks,
//   a table of directed vectors, randomized ops against an arithmetic
//   reference model, start-while-busy and reset-mid-operation sequences.
// ----------------------------------------------------------------------------
module tb_alu_multicycle;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [2:0]    sel;
   logic [W-1:0]  src_a, src_b;
   logic          busy, done, zero, div_zero;
   logic [W-1:0]  result_lo, result_hi;

   int nvec = 0;
   int nerr = 0;

   alu_multicycle #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (rst_n),
      .start     (start),
      .sel       (sel),
      .src_a     (src_a),
      .src_b     (src_b),
      .busy      (busy),
      .done      (done),
      .result_lo (result_lo),
      .result_hi (result_hi),
      .zero      (zero),
      .div_zero  (div_zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] lo;
      logic [W-1:0] hi;
   } vec_t;

   vec_t tbl [15];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference model: {hi, lo} from plain arithmetic on the operands.
   function automatic logic [63:0] ref_op(input logic [2:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
      logic [W-1:0] t;
      logic [63:0]  p;
      case (op)
         3'd0: return {32'h0, a & b};
         3'd1: return {32'h0, a | b};
         3'd2: begin t = a + b; return {32'h0, t}; end
         3'd3: return {32'h0, a ^ b};
         3'd4: begin t = a - b; return {32'h0, t}; end
         3'd5: begin p = 64'(a) * 64'(b); return p; end
         3'd6: return {32'h0, 31'h0, ($signed(a) < $signed(b))};
         default: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
      endcase
   endfunction

   // Issue one op, wait (bounded) for done, check latency and results,
   // then check the block is back in idle the following cycle.
   task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] elo, input logic [W-1:0] ehi, input string tag);
      int cyc;
      int lat;
      logic bad_busy;
      lat = (op == 3'd5 || (op == 3'd7 && b != 0)) ? W + 1 : 1;
      @(negedge clk);
      start = 1'b1; sel = op; src_a = a; src_b = b;
      @(negedge clk);
      // Scramble inputs while busy: operands must have been latched.
      start = 1'b0; sel = 3'($urandom); src_a = $urandom; src_b = $urandom;
      cyc = 1;
      bad_busy = 1'b0;
      while (!done && cyc < 100) begin
         if (!busy) bad_busy = 1'b1;
         @(negedge clk);
         cyc++;
      end
      if (!busy) bad_busy = 1'b1;
      chk({tag, " latency"}, 64'(cyc), 64'(lat));
      chk({tag, " busy"}, 64'(bad_busy), 64'd0);
      chk({tag, " result_lo"}, 64'(result_lo), 64'(elo));
      chk({tag, " result_hi"}, 64'(result_hi), 64'(ehi));
      chk({tag, " zero/div_zero"}, {62'd0, zero, div_zero},
          {62'd0, (elo == 0), (op == 3'd7 && b == 0)});
      @(negedge clk);
      chk({tag, " idle after"}, {62'd0, busy, done}, 64'd0);
   endtask

   initial begin
      int ndone, dcyc, busy34;
      logic [W-1:0] lo_at;
      logic [63:0]  exp;
      logic [2:0]   rop;
      logic [W-1:0] ra, rb;

      tbl[0]  = '{3'd2, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'h0};
      tbl[1]  = '{3'd4, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0};
      tbl[2]  = '{3'd6, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 32'h0};
      tbl[3]  = '{3'd3, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_F0F0, 32'h0};
      tbl[4]  = '{3'd0, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 32'h0};
      tbl[5]  = '{3'd1, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 32'h0};
      tbl[6]  = '{3'd6, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0};
      tbl[7]  = '{3'd6, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 32'h0};
      tbl[8]  = '{3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE};
      tbl[9]  = '{3'd5, 32'd12345,     32'h0000_0000, 32'h0000_0000, 32'h0};
      tbl[10] = '{3'd5, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32'h0000_0001};
      tbl[11] = '{3'd7, 32'd100,       32'd7,         32'd14,        32'd2};
      tbl[12] = '{3'd7, 32'hDEAD_BEEF, 32'h0000_0000, 32'hFFFF_FFFF, 32'hDEAD_BEEF};
      tbl[13] = '{3'd7, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0};
      tbl[14] = '{3'd7, 32'd5,         32'd9,         32'd0,         32'd5};

      rst_n = 1'b0; start = 1'b0; sel = '0; src_a = '0; src_b = '0;

      // Reset held 3 cycles, then 10 idle cycles.
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         if (i == 3) rst_n = 1'b1;
         #1;
         chk("reset/idle flags", {60'd0, busy, done, zero, div_zero}, 64'd0);
         chk("reset/idle results", {result_hi, result_lo}, 64'd0);
      end

      // Directed table.
      for (int i = 0; i < 15; i++)
         run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].lo, tbl[i].hi, $sformatf("vec%0d", i));

      // Randomized ops against the model.
      for (int i = 0; i < 40; i++) begin
         rop = 3'($urandom);
         ra  = $urandom;
         rb  = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
         exp = ref_op(rop, ra, rb);
         run_op(rop, ra, rb, exp[31:0], exp[63:32], $sformatf("rnd%0d op%0d", i, rop));
      end

      // Start while busy: leave div_zero set first so the later clear is visible.
      run_op(3'd7, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 32'h1234_5678, "divz pre");
      @(negedge clk);
      start = 1'b1; sel = 3'd5; src_a = 32'd3; src_b = 32'd4;
      @(negedge clk);
      start = 1'b0;
      ndone = 0; dcyc = 0; busy34 = 1; lo_at = '0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         if (done) begin ndone++; dcyc = cyc; lo_at = result_lo; end
         if (cyc == 34) busy34 = int'(busy);
         start = (cyc == 5) || done;
         sel = 3'd2; src_a = 32'd1; src_b = 32'd1;
         @(negedge clk);
      end
      start = 1'b0;
      chk("busy-start done count", 64'(ndone), 64'd1);
      chk("busy-start done cycle", 64'(dcyc), 64'(W + 1));
      chk("busy-start result", 64'(lo_at), 64'd12);
      chk("busy-start idle after FIN", 64'(busy34), 64'd0);
      chk("busy-start div_zero cleared", 64'(div_zero), 64'd0);
      run_op(3'd2, 32'd1, 32'd2, 32'd3, 32'd0, "post-busy add");

      // Reset in the middle of a divide.
      @(negedge clk);
      start = 1'b1; sel = 3'd7; src_a = 32'd100; src_b = 32'd7;
      @(negedge clk);
      start = 1'b0;
      for (int cyc = 1; cyc < 10; cyc++) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midreset flags", {60'd0, busy, done, zero, div_zero}, 64'd0);
      chk("midreset results", {result_hi, result_lo}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (done || busy) ndone++;
         @(negedge clk);
      end
      chk("midreset no done/busy", 64'(ndone), 64'd0);
      run_op(3'd2, 32'd2, 32'd3, 32'd5, 32'd0, "post-reset add");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   // Global watchdog.
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Parametrised, sequential successor to the single-cycle datapath ALU.
- Executes logic, add/sub and compare ops in one cycle.
- Executes full-width unsigned multiply (shift-add) and unsigned divide (restoring) iteratively, one bit per cycle.
- Sits in the execute stage of the multi-cycle core; the controller stalls on busy and captures results on done.

Parameters:
- WIDTH, 32, operand width in bits (≥4). Also sets multiply/divide iteration count.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- sel  input  3  opcode, captured with start.
- src_a  input  WIDTH  operand A (multiplicand / dividend), captured with start.
- src_b  input  WIDTH  operand B (multiplier / divisor), captured with start.
- busy  output  1  high while an operation is in flight (all states except IDLE).
- done  output  1  one-cycle pulse; results valid from this cycle.
- result_lo  output  WIDTH  primary result; for MULU the low product, for DIVU the quotient.
- result_hi  output  WIDTH  for MULU the high product, for DIVU the remainder; 0 for all other ops.
- zero  output  1  registered, high when result_lo == 0; updated with done.
- div_zero  output  1  registered, set with done when DIVU had src_b == 0; cleared on the next accepted start.

Behaviour:
- Reset (async, reset=0): state=IDLE. busy, done, zero and div_zero are 0. result_lo, result_hi and all internal regs are 0.
- Opcodes:
  - 000 AND, 001 OR, 010 ADD (mod 2^WIDTH), 011 XOR, 100 SUB (mod 2^WIDTH).
  - 101 MULU: 2·WIDTH-bit unsigned product.
  - 110 SLT: signed compare, result_lo = 1 if A<B else 0.
  - 111 DIVU: unsigned quotient/remainder.
- States: IDLE, MUL, DIV, FIN.
- IDLE:
  - start=1: latch sel, src_a, src_b; clear div_zero.
  - Single-cycle op: compute, go to FIN.
  - MULU: acc=0, count=WIDTH, go to MUL.
  - DIVU with src_b≠0: rem=0, count=WIDTH, go to DIV.
  - DIVU with src_b=0: go to FIN with quotient = all ones, remainder = src_a, div_zero=1.
  - start=0: stay in IDLE; outputs hold.
- MUL: one shift-add iteration per cycle (LSB of multiplier). Decrement count; when count reaches 0, go to FIN.
- DIV: one restoring step per cycle (shift in dividend MSB, trial subtract, set quotient bit). Decrement count; when count reaches 0, go to FIN.
- FIN:
  - Registers result_lo, result_hi and zero; done=1 for this cycle only; busy=1.
  - Next state is IDLE.
- Latency (start accepted at edge N):
  - Single-cycle ops and DIVU-by-zero: done high in cycle N+1.
  - MULU and DIVU: done high in cycle N+WIDTH+1.
- start while busy (including the FIN cycle) is ignored; it is neither queued nor stalling. The controller must re-assert start in IDLE.
- Back-to-back: earliest next accept is the cycle after FIN, so throughput is one single-cycle op per 2 cycles.
- Results, zero and div_zero hold their values until the next FIN.
- Operands latched at start; src_a, src_b and sel may change freely while busy.
- Width rules:
  - ADD/SUB carry/borrow discarded; no overflow flag.
  - SLT compares as two's complement.
  - MULU(max,max) = (2^WIDTH−1)², exact.
- Reset mid-operation: immediate abort to IDLE. All outputs are cleared; there is no done pulse.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles, release, start=0 for 10 cycles -> busy=0, done=0, result_lo=0, result_hi=0, zero=0 throughout.
- Single-cycle ops: ADD 0xFFFFFFFF+1 -> done at N+1, result_lo=0, zero=1. SUB 5−7 -> 0xFFFFFFFE. SLT 0xFFFFFFFF<1 -> 1. XOR 0xF0F0F0F0^0xFFFF0000 -> 0x0F0FF0F0. result_hi=0 for all.
- MULU: 0xFFFFFFFF×0xFFFFFFFF -> busy for cycles N+1..N+33, done only at N+33, result_hi=0xFFFFFFFE, result_lo=0x00000001. Also 12345×0 -> both results 0, zero=1.
- DIVU: 100/7 -> done at N+33, result_lo=14, result_hi=2, div_zero=0. 0xDEADBEEF/0 -> done at N+1, result_lo=0xFFFFFFFF, result_hi=0xDEADBEEF, div_zero=1.
- Start while busy: start MULU 3×4, pulse start with ADD at N+5 and at the FIN cycle -> both ignored, single done, result_lo=12. Next start in IDLE accepted normally and clears div_zero.
- Reset mid-op: DIVU begun, reset=0 at N+10 -> busy=0 and outputs 0 immediately. No done pulse afterward. A new ADD 2+3 after release -> 5 at N'+1.
